// File: rtl/digit_serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract datapath.
package serial_arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sa_state_t;

    // Digit counter width; stays at least one bit even for degenerate digit counts.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Digit handshake bundle between the operand shifter, the adder and the result collector.
interface digit_serial_addsub_if #(
    parameter int DIGIT_W = 4
);
    logic               start;
    logic               sub;
    logic               in_valid;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic [DIGIT_W-1:0] sum;
    logic               sum_valid;
    logic               carry;
    logic               busy;
    logic               done;
    logic               ovf;

    modport master (
        output start, sub, in_valid, a, b,
        input  sum, sum_valid, carry, busy, done, ovf
    );

    modport slave (
        input  start, sub, in_valid, a, b,
        output sum, sum_valid, carry, busy, done, ovf
    );
endinterface

// File: rtl/digit_serial_addsub_digit_adder.sv
// One-digit adder; cin_msb is the carry into the top bit, used for signed overflow.
module digit_adder #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               cin_msb
);

    logic [DIGIT_W:0] full_s;

    // Widen before adding so the carry-out is never truncated.
    always_comb begin
        full_s  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        sum     = full_s[DIGIT_W-1:0];
        cout    = full_s[DIGIT_W];
        cin_msb = a[DIGIT_W-1] ^ b[DIGIT_W-1] ^ full_s[DIGIT_W-1];
    end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, LS digit first, running carry in a register.
module digit_serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  aresetn,
    digit_serial_addsub_if.slave  bus
);

    localparam int              CNT_W    = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sa_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT_W-1:0] bx_s;
    logic [DIGIT_W-1:0] sum_s;
    logic               cout_s;
    logic               cin_msb_s;

    // Subtraction is a + ~b + 1, the +1 coming from carry preset at start.
    assign bx_s = mode_q ? ~bus.b : bus.b;

    digit_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit_adder (
        .a       (bus.a),
        .b       (bx_s),
        .cin     (carry_q),
        .sum     (sum_s),
        .cout    (cout_s),
        .cin_msb (cin_msb_s)
    );

    // Next-state and register updates for the operation sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mode_d  = bus.sub;
                    carry_d = bus.sub;
                    cnt_d   = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    carry_d = cout_s;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        ovf_d   = cin_msb_s ^ cout_s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum       = sum_s;
    assign bus.busy      = (state_q == RUN);
    assign bus.sum_valid = (state_q == RUN) & bus.in_valid;
    assign bus.carry     = carry_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Randomized self-checking bench for digit_serial_addsub against whole-operand arithmetic.
module tb_digit_serial_addsub;

    localparam int DW = 4;
    localparam int ND = 4;

    logic clk;
    logic aresetn;
    int   n_cmp;
    int   n_err;

    digit_serial_addsub_if #(.DIGIT_W(DW)) ds_if ();

    digit_serial_addsub #(
        .DIGIT_W    (DW),
        .NUM_DIGITS (ND)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (ds_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation starting at the current negedge; returns in the done cycle.
    task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_sub,
                         input int stall_at, input int stall_len, input bit rnd_gaps,
                         input string tag);
        logic [15:0] res;
        logic [16:0] wide;
        logic [15:0] got;
        logic        exp_c;
        logic        exp_v;
        int          gap;
        wide  = {1'b0, op_a} + {1'b0, op_b};
        res   = op_sub ? (op_a - op_b) : wide[15:0];
        exp_c = op_sub ? (op_a >= op_b) : wide[16];
        if (op_sub) exp_v = (op_a[15] != op_b[15]) && (res[15] != op_a[15]);
        else        exp_v = (op_a[15] == op_b[15]) && (res[15] != op_a[15]);
        got = 16'h0000;

        ds_if.start    = 1'b1;
        ds_if.sub      = op_sub;
        ds_if.in_valid = 1'($urandom_range(0, 1));
        ds_if.a        = 4'($urandom);
        ds_if.b        = 4'($urandom);
        #1;
        check_eq({tag, ".idle_busy"}, ds_if.busy, 1'b0);
        check_eq({tag, ".idle_sv"}, ds_if.sum_valid, 1'b0);
        @(negedge clk);
        ds_if.start = 1'b0;
        check_eq({tag, ".run_busy"}, ds_if.busy, 1'b1);
        check_eq({tag, ".run_done"}, ds_if.done, 1'b0);
        check_eq({tag, ".init_carry"}, ds_if.carry, op_sub);
        check_eq({tag, ".init_ovf"}, ds_if.ovf, 1'b0);

        for (int d = 0; d < ND; d++) begin
            if (d == stall_at) gap = stall_len;
            else if (rnd_gaps && ($urandom_range(0, 3) == 0)) gap = $urandom_range(1, 3);
            else gap = 0;
            for (int g = 0; g < gap; g++) begin
                ds_if.in_valid = 1'b0;
                ds_if.start    = rnd_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                ds_if.sub      = 1'($urandom);
                ds_if.a        = 4'($urandom);
                ds_if.b        = 4'($urandom);
                #1;
                check_eq({tag, ".stall_sv"}, ds_if.sum_valid, 1'b0);
                check_eq({tag, ".stall_busy"}, ds_if.busy, 1'b1);
                @(negedge clk);
            end
            ds_if.in_valid = 1'b1;
            ds_if.start    = (d == ND - 1) ? 1'b1 : 1'b0;
            ds_if.sub      = 1'($urandom);
            ds_if.a        = op_a[4*d +: 4];
            ds_if.b        = op_b[4*d +: 4];
            #1;
            check_eq({tag, ".digit"}, ds_if.sum, res[4*d +: 4]);
            check_eq({tag, ".sv"}, ds_if.sum_valid, 1'b1);
            check_eq({tag, ".early_done"}, ds_if.done, 1'b0);
            got[4*d +: 4] = ds_if.sum;
            @(negedge clk);
        end
        ds_if.start    = 1'b0;
        ds_if.in_valid = 1'b0;
        check_eq({tag, ".done"}, ds_if.done, 1'b1);
        check_eq({tag, ".end_busy"}, ds_if.busy, 1'b0);
        check_eq({tag, ".carry"}, ds_if.carry, exp_c);
        check_eq({tag, ".ovf"}, ds_if.ovf, exp_v);
        check_eq({tag, ".result"}, got, res);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] corner [4];
        corner[0] = 16'h0000;
        corner[1] = 16'h7FFF;
        corner[2] = 16'h8000;
        corner[3] = 16'hFFFF;
        n_cmp = 0;
        n_err = 0;

        aresetn        = 1'b0;
        ds_if.start    = 1'b0;
        ds_if.sub      = 1'b0;
        ds_if.in_valid = 1'b1;
        ds_if.a        = 4'hF;
        ds_if.b        = 4'hF;
        #3;
        check_eq("rst.busy", ds_if.busy, 1'b0);
        check_eq("rst.sv", ds_if.sum_valid, 1'b0);
        check_eq("rst.carry", ds_if.carry, 1'b0);
        check_eq("rst.done", ds_if.done, 1'b0);
        check_eq("rst.ovf", ds_if.ovf, 1'b0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        do_op(16'h1234, 16'h0FFF, 1'b0, -1, 0, 1'b0, "add");
        do_op(16'h0005, 16'h0007, 1'b1, -1, 0, 1'b0, "sub");
        do_op(16'h7FFF, 16'h0001, 1'b0, -1, 0, 1'b0, "sovf");
        do_op(16'hFFFF, 16'h0001, 1'b0, -1, 0, 1'b0, "wrap");
        do_op(16'h1234, 16'h0FFF, 1'b0, 2, 2, 1'b0, "stall");

        // Abort mid-operation with an asynchronous reset between clock edges.
        @(negedge clk);
        ds_if.start = 1'b1;
        ds_if.sub   = 1'b0;
        @(negedge clk);
        ds_if.start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ds_if.in_valid = 1'b1;
            ds_if.a        = 4'hF;
            ds_if.b        = 4'hF;
            @(negedge clk);
        end
        check_eq("abort.pre_carry", ds_if.carry, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check_eq("abort.busy", ds_if.busy, 1'b0);
        check_eq("abort.carry", ds_if.carry, 1'b0);
        check_eq("abort.done", ds_if.done, 1'b0);
        check_eq("abort.sv", ds_if.sum_valid, 1'b0);
        @(negedge clk);
        check_eq("abort.no_done", ds_if.done, 1'b0);
        aresetn = 1'b1;
        ds_if.in_valid = 1'b0;
        @(negedge clk);
        check_eq("abort.idle_done", ds_if.done, 1'b0);
        check_eq("abort.idle_busy", ds_if.busy, 1'b0);

        do_op(16'h1234, 16'h0FFF, 1'b0, -1, 0, 1'b0, "fresh");

        for (int k = 0; k < 200; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            do_op(ra, rb, 1'($urandom_range(0, 1)), -1, 0, 1'b1, "rnd");
        end

        @(negedge clk);
        check_eq("final.done_pulse", ds_if.done, 1'b0);
        check_eq("final.busy", ds_if.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
